// File: rtl/vga_fb_arbiter.sv
// Shares a 1-bit framebuffer RAM: scan-out reads win, the writer gets the rest; RAM port registered, pixel on o_blue 3 clks after strobe.
// Writer stalls (ack low) until a slot is free; FB_VBLANK_WRITE_EN restricts writes to vertical blanking.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_active,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_data,
  output logic              o_wr_ack,
  output logic              o_wr_err,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_wdata,
  input  logic              i_ram_rdata,
  output logic [3:0]        o_blue
);

  typedef enum logic [1:0] {S_IDLE, S_DRD, S_WR} state_t;

  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic              rd_pend;
  logic              pix_q;
  logic              act_q;
  logic              ack_sent;
  logic              disp_req;
  logic              wr_allowed;
  logic              wr_grant;
  logic              wr_in_range;
  logic [ADDR_W-1:0] disp_addr;

  // Reset asserts immediately, releases two clocks after i_rst_n rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

`ifdef FB_VBLANK_WRITE_EN
  assign wr_allowed = !i_active && (i_y == 9'(V_ACTIVE - 1));
`else
  assign wr_allowed = 1'b1;
`endif

  // y*640 as shifts, kept at full address width.
  assign disp_addr   = (ADDR_W'(i_y) << 9) + (ADDR_W'(i_y) << 7) + ADDR_W'(i_x);
  assign disp_req    = i_pix_stb && i_active;
  assign wr_grant    = !disp_req && i_wr_req && wr_allowed && !ack_sent;
  assign wr_in_range = i_wr_addr < FB_SIZE;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_pend     <= 1'b0;
      pix_q       <= 1'b0;
      act_q       <= 1'b0;
      ack_sent    <= 1'b0;
      o_wr_ack    <= 1'b0;
      o_wr_err    <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= 1'b0;
    end else begin
      o_wr_ack    <= 1'b0;
      o_wr_err    <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_wdata <= 1'b0;
      rd_pend     <= (state == S_DRD);
      if (rd_pend)
        pix_q <= i_ram_rdata;
      if (i_pix_stb) begin
        act_q <= i_active;
        if (!i_active) pix_q <= 1'b0;
      end
      if (!i_wr_req)
        ack_sent <= 1'b0;

      if (disp_req) begin
        state      <= S_DRD;
        o_ram_en   <= 1'b1;
        o_ram_addr <= disp_addr;
      end else if (wr_grant) begin
        state    <= S_WR;
        o_wr_ack <= 1'b1;
        ack_sent <= 1'b1;
        if (wr_in_range) begin
          o_ram_en    <= 1'b1;
          o_ram_we    <= 1'b1;
          o_ram_addr  <= i_wr_addr;
          o_ram_wdata <= i_wr_data;
        end else begin
          o_wr_err <= 1'b1;
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

  assign o_blue = act_q ? {4{pix_q}} : 4'h0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous 1-bit RAM.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 19;
  localparam int FB_N   = 640 * 480;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_stb, active, wr_req, wr_data;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack, wr_err, ram_en, ram_we, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        blue;
  logic              mem [0:FB_N-1];

  int errors = 0;
  int checks = 0;
  int acks;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_active(active),
    .i_x(x), .i_y(y), .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ack(wr_ack), .o_wr_err(wr_err), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_blue(blue)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Strobe one active pixel, then return to no-strobe.
  task automatic strobe(input logic [9:0] px, input logic [8:0] py);
    pix_stb = 1'b1; active = 1'b1; x = px; y = py;
    cyc();
    pix_stb = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; pix_stb = 1'b0; active = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = 1'b0; ram_rdata = 1'b0;
    for (int i = 0; i < FB_N; i++) mem[i] = 1'b0;
    mem[641] = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    check("rst_ram_en", ram_en, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_err", wr_err, 0);
    check("rst_blue", blue, 0);
    rst_n = 1'b1;
    repeat (4) cyc();

    // Scan-out of pixel (1,1) holding 1, then (2,1) holding 0.
    strobe(10'd1, 9'd1);
    check("t2_en", ram_en, 1);
    check("t2_we", ram_we, 0);
    check("t2_addr", ram_addr, 641);
    repeat (2) cyc();
    check("t2_blue_on", blue, 4'hF);
    strobe(10'd2, 9'd1);
    check("t2_addr2", ram_addr, 642);
    repeat (2) cyc();
    check("t2_blue_off", blue, 0);
    strobe(10'd639, 9'd479);
    check("t2_addr_last", ram_addr, FB_N - 1);
    repeat (2) cyc();

    // Blanking strobe: no read, pixel cleared.
    strobe(10'd1, 9'd1);
    repeat (2) cyc();
    check("blank_pre", blue, 4'hF);
    pix_stb = 1'b1; active = 1'b0;
    cyc();
    pix_stb = 1'b0;
    check("blank_no_rd", ram_en, 0);
    check("blank_blue", blue, 0);
    repeat (2) cyc();

    // Collision: write request arrives with an active strobe.
    wr_req = 1'b1; wr_addr = 19'd5; wr_data = 1'b1;
    strobe(10'd3, 9'd0);
    active = 1'b0; y = 9'd479;
    check("t3_rd_first", ram_we, 0);
    check("t3_rd_addr", ram_addr, 3);
    check("t3_no_ack_yet", wr_ack, 0);
    cyc();
    check("t3_ack", wr_ack, 1);
    check("t3_we", ram_we, 1);
    check("t3_waddr", ram_addr, 5);
    check("t3_err", wr_err, 0);
    wr_req = 1'b0;
    cyc();
    check("t3_ack_pulse", wr_ack, 0);
    check("t3_mem", mem[5], 1);
    strobe(10'd5, 9'd0);
    repeat (2) cyc();
    check("t3_readback", blue, 4'hF);
    active = 1'b0; y = 9'd479;

    // Out-of-range write.
    wr_req = 1'b1; wr_addr = 19'(FB_N); wr_data = 1'b1;
    cyc();
    check("t4_ack", wr_ack, 1);
    check("t4_err", wr_err, 1);
    check("t4_en", ram_en, 0);
    wr_req = 1'b0;
    cyc();
    check("t4_ack_clr", wr_ack, 0);
    check("t4_err_clr", wr_err, 0);

    // Held request: one ack only; drop and re-raise gives another.
    acks = 0;
    wr_req = 1'b1; wr_addr = 19'd10; wr_data = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      acks += int'(wr_ack);
    end
    check("t5_one_ack", acks, 1);
    wr_req = 1'b0;
    cyc();
    acks = 0;
    wr_req = 1'b1; wr_addr = 19'd11;
    for (int i = 0; i < 3; i++) begin
      cyc();
      acks += int'(wr_ack);
    end
    check("t5_second_ack", acks, 1);
    wr_req = 1'b0;
    cyc();

    // Request during active video at (100,200).
    active = 1'b1; x = 10'd100; y = 9'd200;
    wr_req = 1'b1; wr_addr = 19'd20; wr_data = 1'b1;
    acks = 0;
`ifdef FB_VBLANK_WRITE_EN
    for (int i = 0; i < 6; i++) begin
      cyc();
      acks += int'(wr_ack);
    end
    check("t6_stall", acks, 0);
    active = 1'b0; y = 9'd479;
`endif
    for (int i = 0; i < 2; i++) begin
      cyc();
      acks += int'(wr_ack);
    end
    check("t6_ack", acks, 1);
    wr_req = 1'b0;
    cyc();

    // Reset with a write pending and a lit pixel.
    strobe(10'd1, 9'd1);
    repeat (2) cyc();
    check("t1_pre_blue", blue, 4'hF);
    active = 1'b0; y = 9'd479;
    wr_req = 1'b1; wr_addr = 19'd30; wr_data = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t1_blue", blue, 0);
    check("t1_en", ram_en, 0);
    repeat (2) cyc();
    check("t1_no_ack", wr_ack, 0);
    check("t1_no_write", mem[30], 0);
    wr_req = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
